fwft_read_fifo: RTL

FWFT_READ_FIFO -- requirements
Module: fwft_read_fifo

---
 rtl/fwft_read_fifo_if.sv | 39 +++
 rtl/fwft_read_fifo.sv | 104 ++++++++++
 2 files changed

// File: rtl/fwft_read_fifo_if.sv
//------------------------------------------------------------------------------
// Module      : fwft_read_fifo_if
// Description : Bundles the write, read and status signals of the
//               first-word-fall-through FIFO. The master side issues
//               requests and the slave side (the FIFO) answers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fwft_read_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] din;
    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;

    // Requester side: drives data and requests, observes status
    modport master (
        output din, wr, rd,
        input  dout, full, empty, count, overflow, underflow
    );

    // FIFO side: accepts requests, drives data and status
    modport slave (
        input  din, wr, rd,
        output dout, full, empty, count, overflow, underflow
    );
endinterface

`default_nettype wire

// File: rtl/fwft_read_fifo.sv
//------------------------------------------------------------------------------
// Module      : fwft_read_fifo
// Description : Synchronous FIFO with first-word-fall-through read data.
//               The oldest entry is visible on dout without a read cycle;
//               rd pops it. Full/empty come from an occupancy counter, and
//               dropped writes / ignored reads raise registered one-cycle
//               overflow / underflow pulses. Reset is asynchronous and
//               clears the storage as well as the control state.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fwft_read_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    fwft_read_fifo_if.slave     bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occupancy;
    logic                  overflow_q;
    logic                  underflow_q;

    logic                  is_full;
    logic                  is_empty;
    logic                  wr_accept;
    logic                  rd_accept;

    // Status is taken from the occupancy counter: pointers are equal both
    // when empty and when full, so they cannot tell the two apart.
    assign is_full   = (occupancy == FULL_COUNT);
    assign is_empty  = (occupancy == '0);

    // A write to a full FIFO still lands if the same cycle pops an entry,
    // because the pop frees the slot the write pointer is about to reuse.
    assign wr_accept = bus.wr && (!is_full || bus.rd);
    assign rd_accept = bus.rd && !is_empty;

    // Storage array: cleared by reset so stale data never reappears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_accept) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_accept, rd_accept})
                2'b10:   occupancy <= occupancy + CNT_ONE;
                2'b01:   occupancy <= occupancy - CNT_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Error pulses: registered, high for the single cycle after the request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= bus.wr && is_full && !bus.rd;
            underflow_q <= bus.rd && is_empty;
        end
    end

    // Fall-through read data; forced to zero while nothing is stored
    assign bus.dout      = is_empty ? '0 : mem[rd_ptr];
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.count     = occupancy;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

`default_nettype wire
